data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Shares the single-ported data memory between two requesters: port A (instruction fetch) and port B (load/store unit).
- Sits between the requesters and the memory, which uses word addressing, has DEPTH words, and has level-sensitive memRead/memWrite strobes.
- Performs round-robin arbitration and sequences each access over a fixed number of cycles.
- Returns read data and a one-cycle done pulse to the winning requester.

Parameters:
- DEPTH, 16: number of 32-bit words in the memory. Legal addresses are 0..DEPTH-1.
- LATENCY, 2: number of cycles the strobe is held per access. Legal range is 1..15.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion forces reset state immediately; release is sampled on the clock.
- aReq  input  1  port A request; held high until aDone.
- aWrite  input  1  port A: 1 = write, 0 = read.
- aAddress  input  32  port A word address.
- aWriteData  input  32  port A store data.
- aGrant  output  1  high while port A owns the memory.
- aDone  output  1  one-cycle completion pulse for port A.
- aReadData  output  32  port A read result.
- bReq, bWrite, bAddress, bWriteData, bGrant, bDone, bReadData: same as the port A signals, for port B.
- memAddress  output  32  address to the memory.
- memWriteData  output  32  write data to the memory.
- memRead  output  1  memory read strobe.
- memWrite  output  1  memory write strobe.
- memReadData  input  32  memory read data.
- addrError  output  1  one-cycle pulse, coincident with xDone, when the address is >= DEPTH.

Behaviour:
- Reset values:
  - State IDLE; priority pointer = A.
  - All grants, dones, strobes and addrError = 0.
  - memAddress, memWriteData, aReadData and bReadData = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Sample aReq and bReq.
  - If only one is high, that port wins. If both are high, the port named by the pointer wins. If neither is high, stay in IDLE.
  - On a win, in the next cycle: raise the winner's grant; latch its address, write flag and write data into memAddress, memWriteData and an internal op register; go to ACCESS.
  - The pointer moves to the loser when the grant is issued, so back-to-back contention alternates A, B, A, B.
- ACCESS:
  - Drive memRead (read op) or memWrite (write op) for exactly LATENCY consecutive cycles. A 4-bit counter counts 0..LATENCY-1.
  - Never assert memRead and memWrite together.
  - memAddress and memWriteData stay stable for the whole of ACCESS.
  - On the last ACCESS cycle of a read, capture memReadData into the winner's xReadData register.
  - Then go to DONE.
- Out-of-range address (latched address >= DEPTH):
  - No strobe is asserted.
  - ACCESS still lasts LATENCY cycles, so timing is deterministic.
  - xReadData is loaded with 0.
  - addrError pulses together with xDone.
- DONE:
  - Strobes are low.
  - xDone is high for exactly one cycle, and xGrant stays high during that cycle.
  - Next cycle: grant drops and state returns to IDLE.
- Request latency: from the cycle req is sampled high in IDLE to xDone = LATENCY + 2 cycles.
- Throughput: one access per LATENCY + 3 cycles, because IDLE always takes one cycle.
- xReadData holds its last value until that port's next read completes. A write leaves xReadData unchanged.
- Requesters must hold req, write, address and write data stable until done. Changes to these after the grant are ignored.
- A requester that drops req before its grant is simply not served; this is not an error.
- Reset mid-access: strobes drop immediately and asynchronously, and no done is issued. The memory access is abandoned; the memory contents for that word are undefined for a write.
- Only one grant is ever high at a time.
- Address width is 32 bits, but only the bounds check and the pass-through use it; the memory itself indexes address[3:0] when DEPTH = 16.

Test Plan:
- Single read:
  - Stimulus: preload mem[5] = 0xDEADBEEF; assert aReq, aWrite = 0, aAddress = 5.
  - Required: aGrant next cycle; memRead high for 2 cycles with memAddress = 5; aDone at cycle 4 after the request; aReadData = 0xDEADBEEF.
- Write then read:
  - Stimulus: B writes 0x12345678 to address 3, then A reads address 3.
  - Required: memWrite high for 2 cycles with memWriteData = 0x12345678; A then reads 0x12345678; memRead and memWrite never high together.
- Contention:
  - Stimulus: aReq and bReq held high continuously for 4 transactions from reset.
  - Required: grant order A, B, A, B; each transaction 5 cycles apart; never both grants high.
- Out-of-range address:
  - Stimulus: aAddress = 16 (DEPTH = 16).
  - Required: no strobe; aDone and addrError pulse together at cycle 4; aReadData = 0.
- Reset mid-ACCESS:
  - Stimulus: drive reset low during the first strobe cycle.
  - Required: memRead, grants and dones go to 0 within the same cycle (asynchronous); after release, the FSM is in IDLE and the pointer = A.
- LATENCY = 1 build:
  - Stimulus: a single read with the build parameter LATENCY = 1.
  - Required: strobe lasts 1 cycle; done arrives 3 cycles after the request.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between an
// instruction-fetch port (A) and a load/store port (B), with fixed-length access sequencing.
module data_memory_arbiter #(
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        aReq,
    input  logic        aWrite,
    input  logic [31:0] aAddress,
    input  logic [31:0] aWriteData,
    output logic        aGrant,
    output logic        aDone,
    output logic [31:0] aReadData,
    input  logic        bReq,
    input  logic        bWrite,
    input  logic [31:0] bAddress,
    input  logic [31:0] bWriteData,
    output logic        bGrant,
    output logic        bDone,
    output logic [31:0] bReadData,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memReadData,
    output logic        addrError
);

    localparam logic [3:0]  LAST_CNT  = 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;          // 0 = A has priority, 1 = B
    logic        owner_q, owner_d;      // 0 = A owns the memory, 1 = B
    logic        op_write_q, op_write_d;
    logic        in_range_q, in_range_d;
    logic        run_q, run_d;          // high while the strobe window is open
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    logic        win_b;
    logic [31:0] sel_addr;
    logic [31:0] rd_value;

    assign win_b    = bReq && (!aReq || ptr_q);
    assign sel_addr = win_b ? bAddress : aAddress;
    assign rd_value = in_range_q ? memReadData : 32'h0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            op_write_q <= 1'b0;
            in_range_q <= 1'b0;
            run_q      <= 1'b0;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            a_rdata_q  <= 32'h0;
            b_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            op_write_q <= op_write_d;
            in_range_q <= in_range_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        op_write_d = op_write_q;
        in_range_d = in_range_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (aReq || bReq) begin
                    owner_d    = win_b;
                    ptr_d      = !win_b;
                    op_write_d = win_b ? bWrite : aWrite;
                    addr_d     = sel_addr;
                    wdata_d    = win_b ? bWriteData : aWriteData;
                    in_range_d = sel_addr < DEPTH_W;
                    run_d      = 1'b0;
                    cnt_d      = 4'd0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // The grant cycle opens the strobe window; the window then spans LATENCY cycles.
                if (!run_q) begin
                    run_d = 1'b1;
                    cnt_d = 4'd0;
                end else if (cnt_q == LAST_CNT) begin
                    run_d   = 1'b0;
                    state_d = DONE;
                    if (!op_write_q) begin
                        if (owner_q) b_rdata_d = rd_value;
                        else         a_rdata_d = rd_value;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic busy;
    logic strobe;
    logic in_done;

    assign busy    = state_q != IDLE;
    assign strobe  = run_q && in_range_q;
    assign in_done = state_q == DONE;

    assign aGrant       = busy && !owner_q;
    assign bGrant       = busy && owner_q;
    assign aDone        = in_done && !owner_q;
    assign bDone        = in_done && owner_q;
    assign addrError    = in_done && !in_range_q;
    assign memRead      = strobe && !op_write_q;
    assign memWrite     = strobe && op_write_q;
    assign memAddress   = addr_q;
    assign memWriteData = wdata_q;
    assign aReadData    = a_rdata_q;
    assign bReadData    = b_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: vector table of single transactions plus
// hand-written contention, mid-access reset and LATENCY = 1 sequences.
module tb_data_memory_arbiter;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        aReq = 1'b0, aWrite = 1'b0, bReq = 1'b0, bWrite = 1'b0;
    logic [31:0] aAddress = 32'h0, aWriteData = 32'h0, bAddress = 32'h0, bWriteData = 32'h0;
    logic        aGrant, aDone, bGrant, bDone, memRead, memWrite, addrError;
    logic [31:0] aReadData, bReadData, memAddress, memWriteData, memReadData;

    logic        l1_aReq = 1'b0;
    logic [31:0] l1_aAddress = 32'h0;
    logic        l1_aGrant, l1_aDone, l1_bGrant, l1_bDone, l1_memRead, l1_memWrite, l1_addrError;
    logic [31:0] l1_aReadData, l1_bReadData, l1_memAddress, l1_memWriteData, l1_memReadData;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    data_memory_arbiter #(.DEPTH(16), .LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .aReq(aReq), .aWrite(aWrite), .aAddress(aAddress), .aWriteData(aWriteData),
        .aGrant(aGrant), .aDone(aDone), .aReadData(aReadData),
        .bReq(bReq), .bWrite(bWrite), .bAddress(bAddress), .bWriteData(bWriteData),
        .bGrant(bGrant), .bDone(bDone), .bReadData(bReadData),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memRead(memRead), .memWrite(memWrite), .memReadData(memReadData),
        .addrError(addrError)
    );

    data_memory_arbiter #(.DEPTH(16), .LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset(reset),
        .aReq(l1_aReq), .aWrite(1'b0), .aAddress(l1_aAddress), .aWriteData(32'h0),
        .aGrant(l1_aGrant), .aDone(l1_aDone), .aReadData(l1_aReadData),
        .bReq(1'b0), .bWrite(1'b0), .bAddress(32'h0), .bWriteData(32'h0),
        .bGrant(l1_bGrant), .bDone(l1_bDone), .bReadData(l1_bReadData),
        .memAddress(l1_memAddress), .memWriteData(l1_memWriteData),
        .memRead(l1_memRead), .memWrite(l1_memWrite), .memReadData(l1_memReadData),
        .addrError(l1_addrError)
    );

    // Memory model: combinational read, write applied mid-cycle while the strobe is high.
    logic [31:0] mem [16];
    assign memReadData    = mem[memAddress[3:0]];
    assign l1_memReadData = (l1_memAddress == 32'd7) ? 32'hCAFE_F00D : 32'h0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[5]  = 32'hDEAD_BEEF;
        mem[15] = 32'hA5A5_0F0F;
        forever begin
            @(negedge clock);
            if (memWrite) mem[memAddress[3:0]] = memWriteData;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        chk("strobe_exclusive", 32'(memRead && memWrite), 32'h0);
        chk("grant_exclusive", 32'(aGrant && bGrant), 32'h0);
    end

    typedef struct {
        logic        port;      // 0 = A, 1 = B
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata; // owner's xReadData after done
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called in an IDLE cycle; k counts cycles after the request is sampled.
    task automatic run_txn(input vec_t v, input int idx);
        logic busy, strb;
        if (!v.port) begin
            aReq = 1'b1; aWrite = v.wr; aAddress = v.addr; aWriteData = v.wdata;
        end else begin
            bReq = 1'b1; bWrite = v.wr; bAddress = v.addr; bWriteData = v.wdata;
        end
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            busy = (k <= LAT + 2);
            strb = (k >= 2) && (k <= LAT + 1) && !v.exp_err;
            chk($sformatf("v%0d c%0d aGrant", idx, k), 32'(aGrant), 32'(busy && !v.port));
            chk($sformatf("v%0d c%0d bGrant", idx, k), 32'(bGrant), 32'(busy && v.port));
            chk($sformatf("v%0d c%0d memRead", idx, k), 32'(memRead), 32'(strb && !v.wr));
            chk($sformatf("v%0d c%0d memWrite", idx, k), 32'(memWrite), 32'(strb && v.wr));
            chk($sformatf("v%0d c%0d aDone", idx, k), 32'(aDone), 32'(k == LAT + 2 && !v.port));
            chk($sformatf("v%0d c%0d bDone", idx, k), 32'(bDone), 32'(k == LAT + 2 && v.port));
            chk($sformatf("v%0d c%0d addrError", idx, k), 32'(addrError), 32'(k == LAT + 2 && v.exp_err));
            if (k <= LAT + 1) chk($sformatf("v%0d c%0d memAddress", idx, k), memAddress, v.addr);
            if (strb && v.wr) chk($sformatf("v%0d c%0d memWriteData", idx, k), memWriteData, v.wdata);
            if (k == 1) begin
                // Requester misbehaves after the grant; the latched values must hold.
                if (!v.port) begin aAddress = 32'hFF; aWriteData = 32'h0; end
                else         begin bAddress = 32'hFF; bWriteData = 32'h0; end
            end
            if (k == LAT + 2) begin
                chk($sformatf("v%0d readData", idx), v.port ? bReadData : aReadData, v.exp_rdata);
                aReq = 1'b0;
                bReq = 1'b0;
            end
        end
        $display("txn %0d port=%s wr=%0d addr=%h done", idx, v.port ? "B" : "A", v.wr, v.addr);
    endtask

    initial begin
        logic        g_port [4];
        int          g_cyc  [4];
        int          n_ev;
        logic        prev_busy;

        vecs[0]  = '{1'b0, 1'b0, 32'd5,          32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'd3,          32'h1234_5678, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'd3,          32'h0,         32'h1234_5678, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'd16,         32'h0,         32'h0,         1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'd3,          32'h0,         32'h1234_5678, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'd20,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'd4,          32'h0,         32'h1000_0004, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'd15,         32'h0000_0001, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'd15,         32'h0,         32'h0000_0001, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h8000_0005,  32'h0,         32'h0,         1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'd0,          32'h0,         32'h1000_0000, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst aGrant", 32'(aGrant), 32'h0);
        chk("rst bGrant", 32'(bGrant), 32'h0);
        chk("rst strobes", 32'({memRead, memWrite}), 32'h0);
        chk("rst dones", 32'({aDone, bDone, addrError}), 32'h0);
        chk("rst memAddress", memAddress, 32'h0);
        chk("rst memWriteData", memWriteData, 32'h0);
        chk("rst aReadData", aReadData, 32'h0);
        chk("rst bReadData", bReadData, 32'h0);
        reset = 1'b1;
        tick();
        chk("idle no grant", 32'({aGrant, bGrant}), 32'h0);

        for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

        // Contention from reset: A, B, A, B at 5-cycle spacing
        reset = 1'b0;
        tick();
        aReq = 1'b1; aWrite = 1'b0; aAddress = 32'd1;
        bReq = 1'b1; bWrite = 1'b0; bAddress = 32'd2;
        reset = 1'b1;
        n_ev = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 40 && n_ev < 4; c++) begin
            tick();
            if ((aGrant || bGrant) && !prev_busy) begin
                g_port[n_ev] = bGrant;
                g_cyc[n_ev]  = c;
                n_ev++;
            end
            prev_busy = aGrant || bGrant;
        end
        aReq = 1'b0;
        bReq = 1'b0;
        chk("contention grant count", 32'(n_ev), 32'd4);
        for (int i = 0; i < n_ev; i++) begin
            chk($sformatf("contention grant %0d port", i), 32'(g_port[i]), 32'(i % 2));
            if (i > 0) chk($sformatf("contention spacing %0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd5);
        end
        $display("contention: %0d grants observed", n_ev);
        for (int i = 0; i < 6; i++) tick();

        // Reset during the first strobe cycle
        aReq = 1'b1; aWrite = 1'b0; aAddress = 32'd5;
        tick();
        chk("rstmid grant", 32'(aGrant), 32'h1);
        tick();
        chk("rstmid memRead before", 32'(memRead), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rstmid memRead async", 32'(memRead), 32'h0);
        chk("rstmid aGrant async", 32'(aGrant), 32'h0);
        chk("rstmid dones async", 32'({aDone, bDone}), 32'h0);
        chk("rstmid memAddress async", memAddress, 32'h0);
        tick();
        reset = 1'b1;
        bReq = 1'b1; bWrite = 1'b0; bAddress = 32'd6;
        tick();
        chk("rstmid pointer A wins", 32'({aGrant, bGrant}), 32'h2);
        for (int i = 0; i < 10 && !aDone; i++) tick();
        chk("rstmid aDone", 32'(aDone), 32'h1);
        chk("rstmid aReadData", aReadData, 32'hDEAD_BEEF);
        aReq = 1'b0;
        for (int i = 0; i < 10 && !bDone; i++) tick();
        chk("rstmid bDone", 32'(bDone), 32'h1);
        chk("rstmid bReadData", bReadData, 32'h1000_0006);
        bReq = 1'b0;
        tick();
        $display("reset-mid-access sequence done");

        // LATENCY = 1 build
        l1_aReq = 1'b1; l1_aAddress = 32'd7;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("l1 c%0d aGrant", k), 32'(l1_aGrant), 32'(k <= 3));
            chk($sformatf("l1 c%0d memRead", k), 32'(l1_memRead), 32'(k == 2));
            chk($sformatf("l1 c%0d memWrite", k), 32'(l1_memWrite), 32'h0);
            chk($sformatf("l1 c%0d aDone", k), 32'(l1_aDone), 32'(k == 3));
            if (k == 3) begin
                chk("l1 aReadData", l1_aReadData, 32'hCAFE_F00D);
                l1_aReq = 1'b0;
            end
        end
        $display("latency-1 read done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
